regfile_bus_ctrl: RTL

- Arbitrates and sequences access to the 8x16-bit general-purpose register file and its shared tri-state data bus, on behalf of NUM_REQ requesters (e.g. fetch/decode, debug port, DMA).
- Each accepted command performs one register transfer: load-immediate, read-out or register-to-register move.
- Generates every regfile control (reg_write, reg_read, input_select, output_select) plus the controller's own bus-drive enable, and guarantees there is never more than one bus driver.
- Sits between the requesters and gp_registers; the top level instantiates the tri-state buffer from bus_drive_en/bus_drive_data.

---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/regfile_bus_ctrl_rr_arbiter.sv | 33 +++
 rtl/regfile_bus_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and state encoding for the register-file bus controller.
package regfile_ctrl_pkg;

  localparam int unsigned OP_W        = 2;
  localparam int unsigned NUM_GP_REGS = 8;

  localparam logic [OP_W-1:0] OP_NOP = 2'b00;
  localparam logic [OP_W-1:0] OP_LDI = 2'b01;
  localparam logic [OP_W-1:0] OP_RD  = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [PTR_W-1:0]   grant_idx_c
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan requesters in rotated order starting from the pointer.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    idx         = '0;
    found       = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = PTR_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_bus_ctrl.sv
// Sequences one register transfer per accepted command and owns all regfile/bus strobes.
module regfile_bus_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SEL_W   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [SEL_W*NUM_REQ-1:0]  req_dst,
  input  logic [SEL_W*NUM_REQ-1:0]  req_src,
  input  logic [DATA_W*NUM_REQ-1:0] req_imm,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      reg_write,
  output logic                      reg_read,
  output logic [SEL_W-1:0]          input_select,
  output logic [SEL_W-1:0]          output_select,
  output logic                      bus_drive_en,
  output logic [DATA_W-1:0]         bus_drive_data,
  input  logic [DATA_W-1:0]         data_bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  state_e              state_q,     state_d;
  logic [PTR_W-1:0]    ptr_q,       ptr_d;
  logic [OP_W-1:0]     op_q,        op_d;
  logic [SEL_W-1:0]    dst_q,       dst_d;
  logic [SEL_W-1:0]    src_q,       src_d;
  logic [DATA_W-1:0]   imm_q,       imm_d;
  logic [NUM_REQ-1:0]  win_q,       win_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                busy_q,      busy_d;
  logic                reg_write_q, reg_write_d;
  logic                reg_read_q,  reg_read_d;
  logic [SEL_W-1:0]    in_sel_q,    in_sel_d;
  logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
  logic                bus_en_q,    bus_en_d;
  logic [DATA_W-1:0]   bus_data_q,  bus_data_d;

  logic [NUM_REQ-1:0]  grant_c;
  logic [PTR_W-1:0]    grant_idx_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Next state and next registered outputs; each output is staged one cycle ahead of its state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    dst_d       = dst_q;
    src_d       = src_q;
    imm_d       = imm_q;
    win_d       = win_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    in_sel_d    = '0;
    out_sel_d   = '0;
    bus_en_d    = 1'b0;
    bus_data_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d     = ST_ACCEPT;
          req_ready_d = grant_c;
          win_d       = grant_c;
          op_d        = req_op[32'(grant_idx_c)*OP_W +: OP_W];
          dst_d       = req_dst[32'(grant_idx_c)*SEL_W +: SEL_W];
          src_d       = req_src[32'(grant_idx_c)*SEL_W +: SEL_W];
          imm_d       = req_imm[32'(grant_idx_c)*DATA_W +: DATA_W];
          ptr_d       = (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + PTR_W'(1);
        end
      end
      ST_ACCEPT: begin
        state_d = ST_EXEC;
        unique case (op_q)
          OP_LDI: begin
            bus_en_d    = 1'b1;
            bus_data_d  = imm_q;
            reg_write_d = 1'b1;
            in_sel_d    = dst_q;
          end
          OP_RD: begin
            reg_read_d = 1'b1;
            out_sel_d  = src_q;
          end
          OP_MOV: begin
            reg_read_d  = 1'b1;
            out_sel_d   = src_q;
            reg_write_d = 1'b1;
            in_sel_d    = dst_q;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_valid_d = win_q;
        if (op_q == OP_RD) rsp_data_d = data_bus;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      imm_q       <= '0;
      win_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      in_sel_q    <= '0;
      out_sel_q   <= '0;
      bus_en_q    <= 1'b0;
      bus_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      imm_q       <= imm_d;
      win_q       <= win_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      bus_en_q    <= bus_en_d;
      bus_data_q  <= bus_data_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = busy_q;
  assign reg_read       = reg_read_q;
  assign input_select   = in_sel_q;
  assign output_select  = out_sel_q;
  assign bus_drive_en   = bus_en_q;
  assign bus_drive_data = bus_data_q;
  // Gated by reset so a write strobe can never land on the same edge as the regfile clear.
  assign reg_write      = reg_write_q & ~reset;

endmodule
